mac_acc: RTL and testbench

Parametrised, pipelined multiply-accumulate unit. It is the sequential successor to the single-bit full-adder cell in the MAC datapath. It takes a stream of operand pairs under a valid/ready handshake, multiplies and accumulates them per packet (delimited by `clear`/`last`), and emits one accumulated result per packet with optional saturation and an overflow flag. It sits between the operand-fetch logic and the result writeback.

---
 rtl/mac_pkg.sv | 45 ++++
 rtl/mac_mult.sv | 52 +++++
 rtl/mac_acc.sv | 130 +++++++++++++
 tb/tb_mac_acc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg
// Shared definitions for the multiply-accumulate slice:
//   beat_ctl_t     - per-beat sideband bits that travel alongside a product
//   sat_max/min    - saturation bounds for a given accumulator width/signedness
//   mac_params_ok  - elaboration-time sanity check of the width parameters
package mac_pkg;

  // Widest accumulator the bound helpers can describe.
  localparam int MAX_ACC_W = 128;

  typedef logic [MAX_ACC_W-1:0] bound_t;

  typedef struct packed {
    logic valid;
    logic clear;
    logic last;
  } beat_ctl_t;

  // Largest representable accumulator value, as an acc_w-bit pattern in the
  // low bits (upper bits zero).
  function automatic bound_t sat_max(input int acc_w, input bit is_signed);
    bound_t r;
    r = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (i < acc_w - 1 || (i == acc_w - 1 && !is_signed)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest representable accumulator value, as an acc_w-bit pattern.
  function automatic bound_t sat_min(input int acc_w, input bit is_signed);
    bound_t r;
    r = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (is_signed && i == acc_w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // The accumulator must hold at least one full product.
  function automatic bit mac_params_ok(input int data_w, input int acc_w);
    return (data_w >= 2) && (acc_w >= 2 * data_w) && (acc_w <= MAX_ACC_W);
  endfunction

endpackage

// File: rtl/mac_mult.sv
// mac_mult
// Registered product stage. Forms the full 2*DATA_W product of a and b
// (two's complement when SIGNED != 0) and registers it with the beat sidebands.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   hold        - freeze the stage (downstream stall)
//   a, b        - operands
//   ctl         - sidebands of the incoming beat (valid = beat accepted)
//   p, p_ctl    - registered product and sidebands
module mac_mult
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  beat_ctl_t             ctl,
  output logic [2*DATA_W-1:0]   p,
  output beat_ctl_t             p_ctl
);

  logic                a_sign;
  logic                b_sign;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;

  // Extending both operands to the product width first lets one unsigned
  // multiplier serve both modes: the low 2*DATA_W bits are the same either way.
  assign a_sign = (SIGNED != 0) && a[DATA_W-1];
  assign b_sign = (SIGNED != 0) && b[DATA_W-1];
  assign a_ext  = {{DATA_W{a_sign}}, a};
  assign b_ext  = {{DATA_W{b_sign}}, b};
  assign prod   = a_ext * b_ext;

  // The product register advances every unstalled cycle; when no beat is
  // accepted the valid sideband simply goes low and the product is don't-care.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p     <= '0;
      p_ctl <= '0;
    end else if (!hold) begin
      p     <= prod;
      p_ctl <= ctl;
    end
  end

endmodule

// File: rtl/mac_acc.sv
// mac_acc
// Pipelined multiply-accumulate unit. Operand pairs arrive under valid/ready,
// are multiplied in mac_mult, then summed per packet (clear = first beat,
// last = final beat). One result per packet is held at the output until taken.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid, in_ready  - operand beat handshake
//   a, b                - operands
//   clear, last         - packet delimiters for the beat
//   out_valid, out_ready- result handshake
//   out_acc             - accumulated (optionally saturated) result
//   overflow            - at least one overflow occurred in the packet
module mac_acc
  import mac_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clear,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              overflow
);

  localparam int EXT_W = ACC_W + 1 - 2 * DATA_W;
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W, SIGNED != 0));

  generate
    if (!mac_params_ok(DATA_W, ACC_W)) begin : g_bad_params
      $error("mac_acc: need DATA_W >= 2 and ACC_W >= 2*DATA_W");
    end
  endgenerate

  logic                stall;
  beat_ctl_t           beat;
  logic [2*DATA_W-1:0] prod;
  beat_ctl_t           pctl;

  logic [ACC_W-1:0]    acc;
  logic                ovf_acc;

  logic                p_sign;
  logic                acc_sign;
  logic [ACC_W:0]      p_ext;
  logic [ACC_W:0]      base;
  logic [ACC_W:0]      sum;
  logic                ovf;
  logic [ACC_W-1:0]    sat_sum;
  logic                sticky;

  // A held, unaccepted result freezes the whole pipeline.
  assign stall    = out_valid && !out_ready;
  assign in_ready = rst_n && !stall;
  assign beat     = {in_valid && in_ready, clear, last};

  mac_mult #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (stall),
    .a     (a),
    .b     (b),
    .ctl   (beat),
    .p     (prod),
    .p_ctl (pctl)
  );

  // One extra bit of headroom is enough: the sum of two in-range values of
  // ACC_W bits always fits in ACC_W+1 bits, so the top bit is the true sign
  // (signed) or the carry out (unsigned).
  assign p_sign   = (SIGNED != 0) && prod[2*DATA_W-1];
  assign acc_sign = (SIGNED != 0) && acc[ACC_W-1];
  assign p_ext    = {{EXT_W{p_sign}}, prod};
  assign base     = pctl.clear ? '0 : {acc_sign, acc};
  assign sum      = base + p_ext;
  assign ovf      = (SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
  assign sticky   = (pctl.clear ? 1'b0 : ovf_acc) | ovf;

  // Clamp to the nearer bound. Unsigned sums can only overflow upwards;
  // a signed overflow goes to whichever side the true sign bit points at.
  always_comb begin
    sat_sum = sum[ACC_W-1:0];
    if (ovf && (SATURATE != 0)) begin
      if ((SIGNED != 0) && sum[ACC_W]) sat_sum = ACC_MIN;
      else                             sat_sum = ACC_MAX;
    end
  end

  // Accumulate and output stage. A consumed result is released first, then a
  // newly finished packet may overwrite it on the same edge, which gives
  // back-to-back results without an idle cycle. Finishing a packet zeroes the
  // accumulator so a following packet without clear still starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (pctl.valid && !stall) begin
        if (pctl.last) begin
          out_acc   <= sat_sum;
          overflow  <= sticky;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_acc   <= 1'b0;
        end else begin
          acc       <= sat_sum;
          ovf_acc   <= sticky;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc
// Drives four mac_acc configurations from one shared stimulus stream:
//   u0: signed,   ACC_W=24, saturating (defaults)
//   u1: signed,   ACC_W=16, saturating
//   u2: signed,   ACC_W=16, wrapping
//   u3: unsigned, ACC_W=16, saturating
// Directed scenarios check known values; a random phase compares every
// delivered result against an arithmetic packet model.
module tb_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        clear;
  logic        last;
  logic        out_ready;

  logic        in_ready0, in_ready1, in_ready2, in_ready3;
  logic        out_valid0, out_valid1, out_valid2, out_valid3;
  logic        overflow0, overflow1, overflow2, overflow3;
  logic [23:0] out_acc0;
  logic [15:0] out_acc1, out_acc2, out_acc3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] v3;
    logic [3:0]  o;
  } exp_t;

  exp_t   expq[$];
  longint macc[4];
  bit     mov[4];
  int     cfg_w[4]   = '{24, 16, 16, 16};
  bit     cfg_s[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit     cfg_sat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  mac_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .clear(clear), .last(last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_acc(out_acc0), .overflow(overflow0));

  mac_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .clear(clear), .last(last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_acc(out_acc1), .overflow(overflow1));

  mac_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .clear(clear), .last(last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_acc(out_acc2), .overflow(overflow2));

  mac_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .a(a), .b(b), .clear(clear), .last(last), .out_valid(out_valid3),
    .out_ready(out_ready), .out_acc(out_acc3), .overflow(overflow3));

  // Free-running clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one beat on the next falling edge.
  task automatic applyStimulus(input bit v, input int av, input int bv,
                               input bit c, input bit l);
    @(negedge clk);
    in_valid = v;
    a        = av[7:0];
    b        = bv[7:0];
    clear    = c;
    last     = l;
  endtask

  // Packet model: plain integer arithmetic, range check, clamp or wrap.
  function automatic void model_accept(input logic [7:0] av, input logic [7:0] bv,
                                       input bit c, input bit l);
    longint pa, pb, lo, hi, m, s;
    longint res[4];
    bit     st;
    bit     ovs[4];
    exp_t   e;
    for (int k = 0; k < 4; k++) begin
      if (cfg_s[k]) begin
        pa = $signed(av);
        pb = $signed(bv);
        lo = -(longint'(1) << (cfg_w[k] - 1));
        hi = (longint'(1) << (cfg_w[k] - 1)) - 1;
      end else begin
        pa = av;
        pb = bv;
        lo = 0;
        hi = (longint'(1) << cfg_w[k]) - 1;
      end
      m  = longint'(1) << cfg_w[k];
      s  = (c ? longint'(0) : macc[k]) + pa * pb;
      st = c ? 1'b0 : mov[k];
      if (s > hi || s < lo) begin
        st = 1'b1;
        if (cfg_sat[k]) s = (s > hi) ? hi : lo;
        else begin
          s = (s - lo) % m;
          if (s < 0) s = s + m;
          s = s + lo;
        end
      end
      res[k] = s;
      ovs[k] = st;
      if (l) begin
        macc[k] = 0;
        mov[k]  = 1'b0;
      end else begin
        macc[k] = s;
        mov[k]  = st;
      end
    end
    if (l) begin
      e.v0 = res[0][23:0];
      e.v1 = res[1][15:0];
      e.v2 = res[2][15:0];
      e.v3 = res[3][15:0];
      e.o  = {ovs[3], ovs[2], ovs[1], ovs[0]};
      expq.push_back(e);
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    clear = 1'b0; last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, want 0", in_ready0); end
    checks++;
    if ({out_valid3, out_valid2, out_valid1, out_valid0} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b, want 0000", {out_valid3, out_valid2, out_valid1, out_valid0}); end
    checks++;
    if (out_acc0 !== 24'd0) begin errors++; $display("[TB] FAIL reset_out_acc: got %0d, want 0", out_acc0); end
    checks++;
    if ({overflow3, overflow2, overflow1, overflow0} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_overflow: got %b, want 0000", {overflow3, overflow2, overflow1, overflow0}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b, want 1", in_ready0); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    applyStimulus(1, 3, 4, 1, 0);
    applyStimulus(1, 5, 6, 0, 0);
    applyStimulus(1, -2, 7, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_early: got out_valid %b, want 0", out_valid0); end
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: got out_valid %b, want 1", out_valid0); end
    checks++;
    if (out_acc0 !== 24'd28) begin errors++; $display("[TB] FAIL basic_acc: got %0d, want 28", $signed(out_acc0)); end
    checks++;
    if (overflow0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf: got %b, want 0", overflow0); end
  endtask

  task automatic test_saturation();
    applyStimulus(1, 127, 127, 1, 0);
    applyStimulus(1, 127, 127, 0, 0);
    applyStimulus(1, 127, 127, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (out_valid1 !== 1'b1 || out_acc1 !== 16'h7FFF || overflow1 !== 1'b1) begin
      errors++; $display("[TB] FAIL sat16: got v=%b acc=%0d ovf=%b, want v=1 acc=32767 ovf=1", out_valid1, $signed(out_acc1), overflow1); end
    checks++;
    if (out_acc2 !== 16'hBD03 || overflow2 !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap16: got acc=%0d ovf=%b, want acc=-17149 ovf=1", $signed(out_acc2), overflow2); end
    checks++;
    if (out_acc0 !== 24'd48387 || overflow0 !== 1'b0) begin
      errors++; $display("[TB] FAIL wide24: got acc=%0d ovf=%b, want acc=48387 ovf=0", out_acc0, overflow0); end
    checks++;
    if (out_acc3 !== 16'd48387 || overflow3 !== 1'b0) begin
      errors++; $display("[TB] FAIL unsigned16: got acc=%0d ovf=%b, want acc=48387 ovf=0", out_acc3, overflow3); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 255, 255, 1, 1);
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (out_valid3 !== 1'b1 || out_acc3 !== 16'd65025) begin
      errors++; $display("[TB] FAIL b2b_first: got v=%b acc=%0d, want v=1 acc=65025", out_valid3, out_acc3); end
    checks++;
    if (out_acc0 !== 24'd1) begin errors++; $display("[TB] FAIL b2b_signed: got %0d, want 1", $signed(out_acc0)); end
    @(negedge clk); #1;
    checks++;
    if (out_valid3 !== 1'b1 || out_acc3 !== 16'd1) begin
      errors++; $display("[TB] FAIL b2b_second: got v=%b acc=%0d, want v=1 acc=1", out_valid3, out_acc3); end
    @(negedge clk); #1;
    checks++;
    if (out_valid3 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got v=%b, want 0", out_valid3); end
  endtask

  task automatic test_backpressure();
    applyStimulus(1, 2, 3, 1, 1);
    out_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 5, 5, 1, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_acc0 !== 24'd6) begin
        errors++; $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b acc=%0d, want rdy=0 v=1 acc=6", i, in_ready0, out_valid0, out_acc0); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got rdy=%b, want 1", in_ready0); end
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got v=%b, want 0", out_valid0); end
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b1 || out_acc0 !== 24'd25) begin
      errors++; $display("[TB] FAIL bp_held_beat: got v=%b acc=%0d, want v=1 acc=25", out_valid0, out_acc0); end
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL bp_single: got v=%b, want 0", out_valid0); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    applyStimulus(1, 10, 10, 1, 0);
    applyStimulus(1, 10, 10, 0, 0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready: got %b, want 0", in_ready0); end
    @(negedge clk); #1;
    checks++;
    if ({out_valid3, out_valid2, out_valid1, out_valid0} !== 4'b0) begin
      errors++; $display("[TB] FAIL rstmid_valid: got %b, want 0000", {out_valid3, out_valid2, out_valid1, out_valid0}); end
    rst_n = 1'b1; in_valid = 1'b1; a = 8'd2; b = 8'd3; clear = 1'b0; last = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b1 || out_acc0 !== 24'd6 || out_acc3 !== 16'd6) begin
      errors++; $display("[TB] FAIL rstmid_result: got v=%b acc=%0d, want v=1 acc=6", out_valid0, out_acc0); end
  endtask

  task automatic test_no_clear();
    applyStimulus(1, 4, 4, 0, 1);
    applyStimulus(1, 1, 2, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checks++;
    if (out_valid0 !== 1'b1 || out_acc0 !== 24'd16) begin
      errors++; $display("[TB] FAIL noclear_first: got v=%b acc=%0d, want v=1 acc=16", out_valid0, out_acc0); end
    @(negedge clk); #1;
    checks++;
    if (out_valid0 !== 1'b1 || out_acc0 !== 24'd2) begin
      errors++; $display("[TB] FAIL noclear_second: got v=%b acc=%0d, want v=1 acc=2", out_valid0, out_acc0); end
  endtask

  task automatic test_random();
    exp_t e;
    bit   drain;
    bit   exp_rdy;
    out_ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin macc[k] = 0; mov[k] = 1'b0; end
    expq.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      drain = (cyc >= 760);
      @(negedge clk);
      in_valid  = !drain && ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      clear     = ($urandom_range(0, 3) == 0);
      last      = ($urandom_range(0, 3) == 0);
      out_ready = drain || ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !(out_valid0 && !out_ready);
      checks++;
      if ({in_ready3, in_ready2, in_ready1, in_ready0} !== {4{exp_rdy}}) begin
        errors++; $display("[TB] FAIL rnd_in_ready cyc %0d: got %b, want %b", cyc, {in_ready3, in_ready2, in_ready1, in_ready0}, {4{exp_rdy}}); end
      checks++;
      if ({out_valid3, out_valid2, out_valid1} !== {3{out_valid0}}) begin
        errors++; $display("[TB] FAIL rnd_valid_align cyc %0d: got %b, want %b", cyc, {out_valid3, out_valid2, out_valid1, out_valid0}, {4{out_valid0}}); end
      if (out_valid0 && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("[TB] FAIL rnd_unexpected cyc %0d: got result %0d, want none", cyc, out_acc0);
        end else begin
          e = expq.pop_front();
          if (out_acc0 !== e.v0 || out_acc1 !== e.v1 || out_acc2 !== e.v2 || out_acc3 !== e.v3 ||
              {overflow3, overflow2, overflow1, overflow0} !== e.o) begin
            errors++;
            $display("[TB] FAIL rnd_result cyc %0d: got %h/%h/%h/%h ovf %b, want %h/%h/%h/%h ovf %b",
                     cyc, out_acc0, out_acc1, out_acc2, out_acc3, {overflow3, overflow2, overflow1, overflow0},
                     e.v0, e.v1, e.v2, e.v3, e.o);
          end
        end
      end
      if (in_valid && in_ready0) model_accept(a, b, clear, last);
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("[TB] FAIL rnd_leftover: got %0d pending, want 0", expq.size()); end
  endtask

  initial begin
    $display("[TB] starting mac_acc bench");
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_no_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
